ltc2600_cmd_sequencer: RTL and testbench

// - Upstream feeder for the LTC2600 serial write engine: buffers DAC commands {command,address,data} in a FIFO.
// - Issues them to the write engine one at a time: pulse send_new_cmd, wait for write_complete, hold a CSB-high gap, then issue the next.
// - Lets firmware or a ramp generator queue a burst of channel updates without polling per write.

---
 rtl/ltc2600_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ltc2600_cmd_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ltc2600_cmd_sequencer.sv
// ltc2600_cmd_sequencer
// Queues LTC2600 DAC commands {command, address, data} and hands them to the
// serial write engine one at a time. Each command is issued with a one-clock
// send_new_cmd pulse. The sequencer then waits for write_complete and holds an
// idle (CSB-high) gap of GAP_CYCLES clocks before it issues the next one.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   cmd_valid/cmd_ready      producer handshake (transfer when both high)
//   cmd_command/address/data command fields pushed into the FIFO
//   send_new_cmd             one-clock start pulse to the write engine
//   command/address/data     in-flight command, changes only on a pop
//   write_complete           write done from engine (rising edge, pulse or level)
//   busy                     FSM not idle or commands still queued
//   fifo_count               queued entries, not counting the in-flight one
//   overflow                 sticky: cmd_valid seen while FIFO full
//   timeout_err              sticky: write_complete never arrived
//   err_clr                  clears overflow/timeout_err (a set in the same cycle wins)
//
// Optional feature: define LTC2600_SEQ_TIMEOUT_EN to abandon a write after
// TIMEOUT_CYCLES clocks in WAIT. Without it WAIT is unbounded and timeout_err
// is tied low.
module ltc2600_cmd_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_command,
  input  logic [3:0]                    cmd_address,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          send_new_cmd,
  output logic [3:0]                    command,
  output logic [3:0]                    address,
  output logic [DATA_WIDTH-1:0]         data,
  input  logic                          write_complete,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 8 + DATA_WIDTH;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t          state_reg, state_next;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic [3:0]      command_reg, address_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic            wc_q_reg;
  logic            overflow_reg;
  logic            push, pop, done, to_hit;

  assign cmd_ready  = (count_reg != CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  // The only pop happens in IDLE, so the FSM is the single FIFO reader.
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  // Edge detect: a level held high produces exactly one completion.
  assign done       = write_complete && !wc_q_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;
  assign command    = command_reg;
  assign address    = address_reg;
  assign data       = data_reg;
  assign overflow   = overflow_reg;

  // Storage has no reset, which leaves it free to map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_command, cmd_address, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      command_reg  <= '0;
      address_reg  <= '0;
      data_reg     <= '0;
      wc_q_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wc_q_reg <= write_complete;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        {command_reg, address_reg, data_reg} <= fifo_mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (cmd_valid && !cmd_ready) overflow_reg <= 1'b1;
      else if (err_clr)            overflow_reg <= 1'b0;
    end
  end

`ifdef LTC2600_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_reg;
  logic          timeout_err_reg;

  // The counter sits at 0 outside WAIT, so it reads 0 in the first WAIT clock.
  // WAIT therefore lasts exactly TIMEOUT_CYCLES clocks before giving up.
  assign to_hit      = (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == WAIT) to_cnt_reg <= to_cnt_reg + TW'(1);
      else                   to_cnt_reg <= '0;
      if (state_reg == WAIT && !done && to_hit) timeout_err_reg <= 1'b1;
      else if (err_clr)                         timeout_err_reg <= 1'b0;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == GAP) gap_cnt_reg <= gap_cnt_reg + GW'(1);
      else                  gap_cnt_reg <= '0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    send_new_cmd = 1'b0;
    case (state_reg)
      IDLE:  if (count_reg != '0) state_next = ISSUE;
      ISSUE: begin
        send_new_cmd = 1'b1;
        state_next   = WAIT;
      end
      WAIT:  if (done || to_hit) state_next = GAP;
      GAP:   if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ltc2600_cmd_sequencer.sv
// Directed bench for ltc2600_cmd_sequencer. Inputs are driven and outputs are
// sampled on the falling edge. A value seen at the falling edge after rising
// edge k is the value the write engine samples at edge k+1.
module tb_ltc2600_cmd_sequencer;
  localparam int DW  = 16;
  localparam int GAP = 4;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, send_new_cmd, write_complete, busy;
  logic overflow, timeout_err, err_clr;
  logic [3:0] cmd_command, cmd_address, command, address;
  logic [DW-1:0] cmd_data, data;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sends  = 0;
  int snap;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  ltc2600_cmd_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .GAP_CYCLES(GAP),
                          .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_command(cmd_command), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .send_new_cmd(send_new_cmd), .command(command), .address(address), .data(data),
    .write_complete(write_complete), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each issued command must be the oldest accepted one still expected.
  always @(negedge clk) begin
    if (send_new_cmd) begin
      logic [23:0] e;
      n_sends++;
      $display("txn send cmd=%h addr=%h data=%h", command, address, data);
      if (exp_q.size() == 0) check("send_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("send_fields", {8'h0, command, address, data}, {8'h0, e});
      end
    end
  end

  // Called at a falling edge; returns one falling edge later with valid low.
  task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_command = c; cmd_address = a; cmd_data = d;
    if (cmd_ready) exp_q.push_back({c, a, d});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    write_complete = 1'b1;
    @(negedge clk);
    write_complete = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   cmd_ready, 1);
    check({tag, "_send"},    send_new_cmd, 0);
    check({tag, "_command"}, command, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_data"},    data, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_count"},   fifo_count, 0);
    check({tag, "_ovf"},     overflow, 0);
    check({tag, "_tmo"},     timeout_err, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_command = '0; cmd_address = '0; cmd_data = '0;
    write_complete = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Single command: accepted at edge N, pulse visible to engine at edge N+2.
    push(4'h3, 4'h2, 16'hABCD);
    check("single_count", fifo_count, 1);
    check("single_no_early_send", send_new_cmd, 0);
    @(negedge clk);
    check("single_send", send_new_cmd, 1);
    check("single_cmd", command, 4'h3);
    check("single_addr", address, 4'h2);
    check("single_data", data, 16'hABCD);
    check("single_busy", busy, 1);
    @(negedge clk);
    check("single_pulse_width", send_new_cmd, 0);
    repeat (18) @(negedge clk);
    pulse_done();
    repeat (GAP - 1) @(negedge clk);
    check("single_busy_in_gap", busy, 1);
    @(negedge clk);
    check("single_busy_fall", busy, 0);
    check("single_hold_data", data, 16'hABCD);

    // Burst: a primer occupies the FSM so eight entries can pile up.
    push(4'h1, 4'h0, 16'h0100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("burst_ready_before", cmd_ready, 1);
      push(4'h3, 4'(i), 16'h1000 + 16'(i * 17));
    end
    check("burst_count_full", fifo_count, 8);
    check("burst_ready_full", cmd_ready, 0);
    check("burst_no_ovf_yet", overflow, 0);
    push(4'h3, 4'hF, 16'hDEAD);
    check("burst_overflow", overflow, 1);
    check("burst_count_after_ovf", fifo_count, 8);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("burst_ovf_cleared", overflow, 0);
    snap = n_sends;
    for (int k = 0; k < 9; k++) begin
      pulse_done();
      repeat (GAP + 3) @(negedge clk);
    end
    check("burst_send_total", n_sends - snap, 8);
    check("burst_drained", exp_q.size(), 0);
    check("burst_idle", busy, 0);

    // Simultaneous push/pop, then level-held done spacing.
    snap = n_sends;
    push(4'h3, 4'h5, 16'h5555);
    check("simul_count_a", fifo_count, 1);
    push(4'h3, 4'h6, 16'h6666);
    check("simul_count_same", fifo_count, 1);
    check("simul_send_a", send_new_cmd, 1);
    @(negedge clk);
    write_complete = 1'b1;
    repeat (GAP + 1) @(negedge clk);
    check("spacing_not_early", send_new_cmd, 0);
    @(negedge clk);
    check("spacing_send_b", send_new_cmd, 1);
    check("spacing_data_b", data, 16'h6666);
    repeat (100 - (GAP + 2)) @(negedge clk);
    write_complete = 1'b0;
    @(negedge clk);
    check("level_one_completion", n_sends - snap, 2);
    check("level_b_still_waiting", busy, 1);
    pulse_done();
    repeat (GAP + 2) @(negedge clk);
    check("level_idle", busy, 0);

    // Reset in WAIT with three queued entries.
    push(4'h3, 4'h7, 16'h7777);
    repeat (3) @(negedge clk);
    push(4'h3, 4'h8, 16'h8888);
    push(4'h3, 4'h9, 16'h9999);
    push(4'h3, 4'hA, 16'hAAAA);
    check("rstmid_count", fifo_count, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_reset_values("rstmid");
    snap = n_sends;
    repeat (3) @(negedge clk);
    pulse_done();
    repeat (20) @(negedge clk);
    check("rstmid_no_send", n_sends - snap, 0);
    check("rstmid_idle", busy, 0);

`ifdef LTC2600_SEQ_TIMEOUT_EN
    // Never complete: first write is dropped after TO clocks, second issues.
    push(4'h3, 4'h1, 16'h1111);
    push(4'h3, 4'h2, 16'h2222);
    check("tmo_send_a", send_new_cmd, 1);
    repeat (TO) @(negedge clk);
    check("tmo_not_yet", timeout_err, 0);
    @(negedge clk);
    check("tmo_set", timeout_err, 1);
    repeat (GAP) @(negedge clk);
    check("tmo_b_not_early", send_new_cmd, 0);
    @(negedge clk);
    check("tmo_send_b", send_new_cmd, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_cleared", timeout_err, 0);
    repeat (TO + GAP + 4) @(negedge clk);
    check("tmo_b_dropped", timeout_err, 1);
    check("tmo_idle", busy, 0);
`else
    // No timeout: WAIT holds indefinitely.
    snap = n_sends;
    push(4'h3, 4'h1, 16'h1111);
    repeat (10000) @(negedge clk);
    check("notmo_sent_once", n_sends - snap, 1);
    check("notmo_still_busy", busy, 1);
    check("notmo_err_low", timeout_err, 0);
    pulse_done();
    repeat (GAP + 2) @(negedge clk);
    check("notmo_idle", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
